// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle RV32M execute unit living beside the single-cycle ALU in EX.
//   Multiplies by shift-add and divides by restoring division, both on operand
//   magnitudes, one bit per cycle. Every operation (special cases included)
//   takes exactly XLEN busy cycles followed by a one-cycle done pulse.
//
// Ports
//   clk    in   1     clock, rising edge
//   rst_n  in   1     asynchronous active-low reset
//   src_a  in   XLEN  operand A (multiplicand / dividend)
//   src_b  in   XLEN  operand B (multiplier / divisor)
//   op     in   3     M-extension funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   start  in   1     request, sampled only while not busy
//   kill   in   1     synchronous flush of the operation in flight
//   busy   out  1     operation in progress (pipeline stalls on it)
//   done   out  1     one-cycle pulse, res valid in the same cycle
//   res    out  XLEN  result, held until the next completed operation
// ----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [2:0]      op,
   input  logic            start,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] res
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_t;

   state_t            state_q, state_d;
   op_t               op_q;
   logic [CW-1:0]     count_q;
   logic [XLEN-1:0]   a_mag_q, b_mag_q;
   logic              neg_q;
   // Multiply: {high, low} product, low half starts as the multiplier.
   // Divide:   {remainder, quotient}, quotient half starts as the dividend.
   logic [2*XLEN-1:0] prod_q, prod_nxt;

   logic              accept, last_iter;

   // ---------------------------------------------------------------------
   // Operand conditioning at accept time
   // ---------------------------------------------------------------------
   op_t             op_in;
   logic            a_signed, b_signed, sign_a, sign_b, neg_in;
   logic [XLEN-1:0] a_mag_in, b_mag_in;

   // NOTE: every variable driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      op_in    = op_t'(op);
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op_in)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      sign_a   = a_signed & src_a[XLEN-1];
      sign_b   = b_signed & src_b[XLEN-1];
      a_mag_in = sign_a ? -src_a : src_a;
      b_mag_in = sign_b ? -src_b : src_b;
      if (!op[2])
         neg_in = sign_a ^ sign_b;                            // product sign
      else if (op[1])
         neg_in = sign_a;                                     // remainder follows dividend
      else
         neg_in = (sign_a ^ sign_b) & (src_b != '0);          // x/0 must stay all ones
   end

   // ---------------------------------------------------------------------
   // One iteration of the datapath
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] prod_hi, prod_lo, div_sub;
   logic [XLEN:0]   add_sum, div_shift;
   logic            div_ge, is_div;

   always_comb begin
      is_div    = op_q[2];
      prod_hi   = prod_q[2*XLEN-1:XLEN];
      prod_lo   = prod_q[XLEN-1:0];
      // Shift-add: conditionally add the multiplicand to the high half, then
      // shift the whole product right, keeping the carry.
      add_sum   = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, a_mag_q} : '0);
      // Restoring step: bring in the next dividend bit, trial-subtract.
      div_shift = {prod_hi, prod_lo[XLEN-1]};
      div_ge    = div_shift >= {1'b0, b_mag_q};
      div_sub   = div_shift[XLEN-1:0] - b_mag_q;
      if (is_div)
         prod_nxt = div_ge ? {div_sub, prod_lo[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], prod_lo[XLEN-2:0], 1'b0};
      else
         prod_nxt = {add_sum, prod_lo[XLEN-1:1]};
   end

   // Sign fix-up applied to the value produced by the final iteration.
   logic [2*XLEN-1:0] mul_fix;
   logic [XLEN-1:0]   div_pick, div_fix, res_nxt;

   always_comb begin
      mul_fix  = neg_q ? -prod_nxt : prod_nxt;
      div_pick = op_q[1] ? prod_nxt[2*XLEN-1:XLEN] : prod_nxt[XLEN-1:0];
      div_fix  = neg_q ? -div_pick : div_pick;
      case (op_q)
         OP_MUL:                       res_nxt = mul_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res_nxt = mul_fix[2*XLEN-1:XLEN];
         default:                      res_nxt = div_fix;
      endcase
   end

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      last_iter = (count_q == CW'(XLEN - 1));
      busy      = (state_q == ST_BUSY);
      done      = (state_q == ST_DONE);
      case (state_q)
         ST_BUSY: begin
            if (kill)
               state_d = ST_IDLE;
            else if (last_iter)
               state_d = ST_DONE;
         end
         default: begin                                       // IDLE and DONE
            accept  = start & ~kill;
            state_d = accept ? ST_BUSY : ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: all datapath registers are reset (there is no array storage here),
   // so an operation interrupted by reset leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= OP_MUL;
         a_mag_q <= '0;
         b_mag_q <= '0;
         neg_q   <= 1'b0;
         count_q <= '0;
         prod_q  <= '0;
         res     <= '0;
      end else if (accept) begin
         op_q    <= op_in;
         a_mag_q <= a_mag_in;
         b_mag_q <= b_mag_in;
         neg_q   <= neg_in;
         count_q <= '0;
         prod_q  <= op[2] ? {{XLEN{1'b0}}, a_mag_in} : {{XLEN{1'b0}}, b_mag_in};
      end else if (state_q == ST_BUSY && !kill) begin
         prod_q  <= prod_nxt;
         count_q <= count_q + CW'(1);
         if (last_iter)
            res <= res_nxt;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit: directed RV32M corner cases, kill,
//   reset mid-operation, then randomized operations (back-to-back and with
//   spurious starts while busy) against a plain-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int XLEN = 32;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic [2:0]  op    = '0;
   logic        start = 1'b0;
   logic        kill  = 1'b0;
   logic        busy, done;
   logic [31:0] res;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_res = '0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .src_a (src_a),
      .src_b (src_b),
      .op    (op),
      .start (start),
      .kill  (kill),
      .busy  (busy),
      .done  (done),
      .res   (res)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: 64-bit products and native 32-bit division.
   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      int          ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      ia = a;
      ib = b;
      case (o)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge, then scramble the inputs so that any
   // dependence on post-accept operand values shows up as a wrong result.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op    = o;
      src_a = a;
      src_b = b;
      start = 1'b1;
      step();
      start = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
      op    = 3'($urandom);
   endtask

   // Entered in the first busy cycle; returns in the done cycle (or on timeout).
   task automatic wait_done(input string tag, input logic [31:0] exp, input bit noise);
      int cycles      = 1;
      int busy_cycles = 0;
      bit seen        = 1'b0;
      while (cycles <= 40) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
         if (noise) begin
            start = 1'($urandom);
            src_a = $urandom;
            src_b = $urandom;
            op    = 3'($urandom);
         end
         step();
         cycles++;
      end
      start = 1'b0;
      check({tag, " done seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, " latency"}, 32'(cycles), 32'd33);
         check({tag, " busy cycles"}, 32'(busy_cycles), 32'd32);
         check({tag, " busy in done"}, 32'(busy), 32'd0);
         check({tag, " res"}, res, exp);
         last_res = exp;
      end
   endtask

   // Step out of the done cycle and confirm the pulse is one cycle wide.
   task automatic leave_done(input string tag);
      step();
      check({tag, " done pulse"}, 32'(done), 32'd0);
   endtask

   typedef struct {
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int done_count;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
      vecs[8]  = '{3'd4, 32'hFFFF_1234, 32'd0,          32'hFFFF_FFFF};
      vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5};
      vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

      // Reset state
      step();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset res", res, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Directed vectors: first one standalone, the rest issued back-to-back
      // in the done cycle of their predecessor.
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].o, vecs[i].a, vecs[i].b);
         wait_done($sformatf("vec%0d", i), vecs[i].exp, (i % 2) == 1);
         if (i == 0) leave_done("vec0");
      end
      leave_done("vec11");

      // Kill in busy cycle 10: drop to idle, never signal done, keep res.
      issue(3'd0, 32'd123, 32'd456);
      repeat (9) step();
      check("kill busy before", 32'(busy), 32'd1);
      kill = 1'b1;
      step();
      kill = 1'b0;
      check("kill busy after", 32'(busy), 32'd0);
      check("kill done after", 32'(done), 32'd0);
      done_count = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) done_count++;
         step();
      end
      check("kill no done", 32'(done_count), 32'd0);
      check("kill res held", res, last_res);

      // Start and kill together while idle: request dropped.
      op    = 3'd3;
      src_a = 32'hFFFF_FFFF;
      src_b = 32'hFFFF_FFFF;
      start = 1'b1;
      kill  = 1'b1;
      step();
      start = 1'b0;
      kill  = 1'b0;
      check("start+kill busy", 32'(busy), 32'd0);
      step();
      check("start+kill done", 32'(done), 32'd0);
      check("start+kill res", res, last_res);

      // Reset mid-operation: everything clears immediately, no done follows.
      issue(3'd5, 32'd1000, 32'd3);
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset res", res, 32'd0);
      last_res = '0;
      step();
      @(negedge clk);
      rst_n = 1'b1;
      done_count = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (done) done_count++;
      end
      check("midreset no done", 32'(done_count), 32'd0);
      check("midreset idle", 32'(busy), 32'd0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  o;
         logic [31:0] a, b;
         bit          b2b;
         o   = 3'($urandom_range(0, 7));
         a   = pick_operand();
         b   = pick_operand();
         b2b = 1'($urandom);
         issue(o, a, b);
         wait_done($sformatf("rand%0d op%0d a=%h b=%h", i, o, a, b), ref_res(o, a, b), 1'b1);
         if (!b2b) leave_done($sformatf("rand%0d", i));
      end
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
